// File: rtl/spi_flash_op_ctrl_if.sv
// Operation, write/read stream, byte-SPI and status signals of the flash operation controller.
// The controller takes the slave view; the requester/SPI side takes the master view.
interface spi_flash_op_ctrl_if;
  logic [1:0]  i_operation_type;
  logic [23:0] i_operation_addr;
  logic [8:0]  i_operation_num;
  logic        i_operation_valid;
  logic        o_operation_ready;

  logic [7:0]  i_write_data;
  logic        i_write_sop;
  logic        i_write_eop;
  logic        i_write_valid;

  logic [7:0]  o_read_data;
  logic        o_read_sop;
  logic        o_read_eop;
  logic        o_read_valid;

  logic [7:0]  o_spi_data;
  logic        o_spi_last;
  logic        o_spi_valid;
  logic        i_spi_ready;
  logic [7:0]  i_spi_rdata;
  logic        i_spi_rvalid;

  logic        o_timeout;

  modport slave (
    input  i_operation_type, i_operation_addr, i_operation_num, i_operation_valid,
    output o_operation_ready,
    input  i_write_data, i_write_sop, i_write_eop, i_write_valid,
    output o_read_data, o_read_sop, o_read_eop, o_read_valid,
    output o_spi_data, o_spi_last, o_spi_valid,
    input  i_spi_ready, i_spi_rdata, i_spi_rvalid,
    output o_timeout
  );

  modport master (
    output i_operation_type, i_operation_addr, i_operation_num, i_operation_valid,
    input  o_operation_ready,
    output i_write_data, i_write_sop, i_write_eop, i_write_valid,
    input  o_read_data, o_read_sop, o_read_eop, o_read_valid,
    input  o_spi_data, o_spi_last, o_spi_valid,
    output i_spi_ready, i_spi_rdata, i_spi_rvalid,
    input  o_timeout
  );
endinterface

// File: rtl/spi_flash_op_ctrl.sv
// SPI NOR erase/program/read sequencer over a byte-SPI master; read bytes leave one cycle after SPI rvalid.
// SPI side is valid/ready (data held while stalled); write and read streams have no backpressure.
module spi_flash_op_ctrl #(
  parameter logic [23:0] P_POLL_MAX = 24'hFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  spi_flash_op_ctrl_if.slave bus
);

  localparam logic [1:0] OP_ERASE = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [3:0] {
    IDLE, WREN, ERASE, PROG_CMD, PROG_DATA, READ_CMD, READ_DATA, POLL, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_type;
  logic [23:0] op_addr;
  logic [8:0]  op_num;
  logic [8:0]  tx_cnt, rx_cnt;
  logic [8:0]  wr_cnt;
  logic        wr_active;
  logic [23:0] poll_cnt;
  logic        wip_q;
  logic        ready_q;
  logic        spi_vld_q, spi_last_q;
  logic [7:0]  spi_dat_q;
  logic        rd_vld_q, rd_sop_q, rd_eop_q;
  logic [7:0]  rd_dat_q;
  logic        timeout_q;
  logic [7:0]  wbuf [256];

  logic        accept, accept_prog;
  logic [8:0]  num_in_eff;
  logic [8:0]  frame_len;
  logic        tx_room, out_free, frame_done;
  logic [8:0]  data_idx;
  logic [7:0]  addr_byte;
  logic        load, load_last;
  logic [7:0]  load_dat;
  logic        frame_clr, poll_again, poll_timeout;
  logic        wr_capture, wr_take;
  logic [8:0]  wr_idx;
  logic        rd_take;
  logic        unused_eop;

  assign unused_eop  = bus.i_write_eop;
  assign accept      = (state == IDLE) & bus.i_operation_valid & ready_q;
  assign accept_prog = accept & (bus.i_operation_type == OP_PROG);
  assign num_in_eff  = ((bus.i_operation_num == 9'd0) || (bus.i_operation_num > 9'd256))
                       ? 9'd256 : bus.i_operation_num;

  always_comb begin
    frame_len = 9'd0;
    case (state)
      WREN:                                   frame_len = 9'd1;
      ERASE:                                  frame_len = 9'd4;
      POLL:                                   frame_len = 9'd2;
      PROG_CMD, PROG_DATA, READ_CMD, READ_DATA: frame_len = 9'd4 + op_num;
      default:                                frame_len = 9'd0;
    endcase
  end

  // A frame ends only once its last byte has left and every response byte is back,
  // so stale rvalids never bleed into the next frame's counters.
  assign tx_room    = tx_cnt < frame_len;
  assign out_free   = ~spi_vld_q | bus.i_spi_ready;
  assign frame_done = (tx_cnt == frame_len) & ~spi_vld_q & (rx_cnt == tx_cnt);
  assign data_idx   = tx_cnt - 9'd4;

  always_comb begin
    addr_byte = 8'h00;
    case (tx_cnt[1:0])
      2'd1:    addr_byte = op_addr[23:16];
      2'd2:    addr_byte = op_addr[15:8];
      2'd3:    addr_byte = op_addr[7:0];
      default: addr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    load_dat     = 8'h00;
    load_last    = 1'b0;
    poll_again   = 1'b0;
    poll_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.i_operation_type)
            OP_ERASE, OP_PROG: state_nxt = WREN;
            OP_READ:           state_nxt = READ_CMD;
            default:           state_nxt = DONE;
          endcase
        end
      end
      WREN: begin
        load      = out_free & tx_room;
        load_dat  = 8'h06;
        load_last = 1'b1;
        if (frame_done) state_nxt = (op_type == OP_PROG) ? PROG_CMD : ERASE;
      end
      ERASE: begin
        load      = out_free & tx_room;
        load_dat  = (tx_cnt == 9'd0) ? 8'h20 : addr_byte;
        load_last = (tx_cnt == 9'd3);
        if (frame_done) state_nxt = POLL;
      end
      PROG_CMD: begin
        load     = out_free;
        load_dat = (tx_cnt == 9'd0) ? 8'h02 : addr_byte;
        if (load && tx_cnt == 9'd3) state_nxt = PROG_DATA;
      end
      PROG_DATA: begin
        // Wait for the requester's stream to fill the next byte before sending it.
        load      = out_free & tx_room & (data_idx < wr_cnt);
        load_dat  = wbuf[data_idx[7:0]];
        load_last = (tx_cnt == frame_len - 9'd1);
        if (frame_done) state_nxt = POLL;
      end
      READ_CMD: begin
        load     = out_free;
        load_dat = (tx_cnt == 9'd0) ? 8'h03 : addr_byte;
        if (load && tx_cnt == 9'd3) state_nxt = READ_DATA;
      end
      READ_DATA: begin
        load      = out_free & tx_room;
        load_dat  = 8'h00;
        load_last = (tx_cnt == frame_len - 9'd1);
        if (frame_done) state_nxt = DONE;
      end
      POLL: begin
        load      = out_free & tx_room;
        load_dat  = (tx_cnt == 9'd0) ? 8'h05 : 8'h00;
        load_last = (tx_cnt == 9'd1);
        if (frame_done) begin
          if (!wip_q) begin
            state_nxt = DONE;
          end else if (poll_cnt == P_POLL_MAX - 24'd1) begin
            poll_timeout = 1'b1;
            state_nxt    = DONE;
          end else begin
            poll_again = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command/address and data phases of program and read share one chip-select frame.
  assign frame_clr = poll_again |
                     ((state_nxt != state) & (state_nxt != PROG_DATA) & (state_nxt != READ_DATA));

  assign wr_capture = bus.i_write_valid & (wr_active | accept_prog);
  assign wr_idx     = bus.i_write_sop ? 9'd0 : (accept_prog ? 9'd0 : wr_cnt);
  assign wr_take    = wr_capture & (wr_idx != 9'd256);
  assign rd_take    = (state == READ_DATA) & bus.i_spi_rvalid & (rx_cnt >= 9'd4);

  always_ff @(posedge i_clk) begin
    if (wr_take) wbuf[wr_idx[7:0]] <= bus.i_write_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q    <= 1'b0;
      op_type    <= 2'd0;
      op_addr    <= 24'd0;
      op_num     <= 9'd0;
      tx_cnt     <= 9'd0;
      rx_cnt     <= 9'd0;
      wr_cnt     <= 9'd0;
      wr_active  <= 1'b0;
      poll_cnt   <= 24'd0;
      wip_q      <= 1'b0;
      spi_vld_q  <= 1'b0;
      spi_last_q <= 1'b0;
      spi_dat_q  <= 8'h00;
      rd_vld_q   <= 1'b0;
      rd_sop_q   <= 1'b0;
      rd_eop_q   <= 1'b0;
      rd_dat_q   <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);

      if (accept) begin
        op_type <= bus.i_operation_type;
        op_addr <= bus.i_operation_addr;
        op_num  <= num_in_eff;
      end

      if (frame_clr)             tx_cnt <= 9'd0;
      else if (load)             tx_cnt <= tx_cnt + 9'd1;
      if (frame_clr)             rx_cnt <= 9'd0;
      else if (bus.i_spi_rvalid) rx_cnt <= rx_cnt + 9'd1;

      if (load) begin
        spi_vld_q  <= 1'b1;
        spi_dat_q  <= load_dat;
        spi_last_q <= load_last;
      end else if (bus.i_spi_ready) begin
        spi_vld_q  <= 1'b0;
      end

      if (accept_prog)                                 wr_active <= 1'b1;
      else if (state == PROG_DATA && state_nxt != PROG_DATA) wr_active <= 1'b0;
      if (wr_take)          wr_cnt <= wr_idx + 9'd1;
      else if (accept_prog) wr_cnt <= 9'd0;

      if (state != POLL)   poll_cnt <= 24'd0;
      else if (poll_again) poll_cnt <= poll_cnt + 24'd1;
      if (state == POLL && bus.i_spi_rvalid && rx_cnt == 9'd1) wip_q <= bus.i_spi_rdata[0];
      if (poll_timeout) timeout_q <= 1'b1;

      rd_vld_q <= rd_take;
      if (rd_take) begin
        rd_dat_q <= bus.i_spi_rdata;
        rd_sop_q <= (rx_cnt == 9'd4);
        rd_eop_q <= (rx_cnt == op_num + 9'd3);
      end else begin
        rd_sop_q <= 1'b0;
        rd_eop_q <= 1'b0;
      end
    end
  end

  assign bus.o_operation_ready = ready_q;
  assign bus.o_spi_valid       = spi_vld_q;
  assign bus.o_spi_data        = spi_dat_q;
  assign bus.o_spi_last        = spi_last_q;
  assign bus.o_read_valid      = rd_vld_q;
  assign bus.o_read_data       = rd_dat_q;
  assign bus.o_read_sop        = rd_sop_q;
  assign bus.o_read_eop        = rd_eop_q;
  assign bus.o_timeout         = timeout_q;

endmodule

// File: tb/tb_spi_flash_op_ctrl.sv
// Scoreboard bench: expected SPI bytes and read beats are queued per operation and popped as the DUT emits them.
module tb_spi_flash_op_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_flash_op_ctrl_if bus();

  spi_flash_op_ctrl #(.P_POLL_MAX(24'd4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_spi [$];   // {last, data}
  logic [9:0] exp_rd  [$];   // {sop, eop, data}
  logic [7:0] pdata [256];

  int         pos;
  logic [7:0] cmd;
  int         wip_ones;
  bit         wip_stuck;
  bit         rand_rdy;
  int         xfers;
  logic       hs, pend, st;
  logic [7:0] resp;
  logic [8:0] tmp9;
  logic [9:0] tmp10;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int neff(input logic [8:0] n);
    return (n == 9'd0 || n > 9'd256) ? 256 : int'(n);
  endfunction

  task automatic push(input logic [7:0] b, input logic l);
    exp_spi.push_back({l, b});
  endtask

  task automatic push_hdr(input logic [7:0] c, input logic [23:0] a, input logic l);
    push(c, 1'b0);
    push(a[23:16], 1'b0);
    push(a[15:8], 1'b0);
    push(a[7:0], l);
  endtask

  task automatic push_poll();
    push(8'h05, 1'b0);
    push(8'h00, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20000 && !bus.o_operation_ready; i++) @(negedge clk);
    check_eq(tag, bus.o_operation_ready, 1);
  endtask

  task automatic do_op(input logic [1:0] t, input logic [23:0] a, input logic [8:0] n);
    wait_idle("op_rdy");
    bus.i_operation_type  = t;
    bus.i_operation_addr  = a;
    bus.i_operation_num   = n;
    bus.i_operation_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_operation_valid = 1'b0;
    @(negedge clk);
    check_eq("rdy_low", bus.o_operation_ready, 0);
  endtask

  task automatic write_stream(input int cnt, input int total, input int gap);
    for (int i = 0; i < cnt; i++) begin
      bus.i_write_valid = 1'b1;
      bus.i_write_data  = pdata[i];
      bus.i_write_sop   = (i == 0);
      bus.i_write_eop   = (i == total - 1);
      @(negedge clk);
      bus.i_write_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.i_write_valid = 1'b0;
    bus.i_write_sop   = 1'b0;
    bus.i_write_eop   = 1'b0;
  endtask

  task automatic do_prog(input logic [23:0] a, input logic [8:0] n, input int gap);
    int ne = neff(n);
    push(8'h06, 1'b1);
    push_hdr(8'h02, a, 1'b0);
    for (int i = 0; i < ne; i++) push(pdata[i], i == ne - 1);
    push_poll();
    do_op(2'd1, a, n);
    write_stream(ne, ne, gap);
    wait_idle("prog_done");
    check_eq("prog_left", exp_spi.size(), 0);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [8:0] n);
    int ne = neff(n);
    push_hdr(8'h03, a, 1'b0);
    for (int i = 0; i < ne; i++) begin
      push(8'h00, i == ne - 1);
      exp_rd.push_back({(i == 0), (i == ne - 1), 8'(i)});
    end
    do_op(2'd2, a, n);
    wait_idle("read_done");
    check_eq("read_spi_left", exp_spi.size(), 0);
    check_eq("read_rd_left", exp_rd.size(), 0);
  endtask

  // SPI slave model and output monitor: sample at negedge, respond after the next posedge.
  initial begin
    bus.i_spi_ready  = 1'b0;
    bus.i_spi_rvalid = 1'b0;
    bus.i_spi_rdata  = 8'h00;
    pos  = 0;
    cmd  = 8'h00;
    pend = 1'b0;
    resp = 8'h00;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (!rst_n) begin
        pos = 0;
      end else begin
        hs = bus.o_spi_valid & bus.i_spi_ready;
        if (bus.o_spi_valid) begin
          if (exp_spi.size() == 0) check_eq("spi_extra", bus.o_spi_valid, 0);
          else check_eq("spi_byte", {bus.o_spi_last, bus.o_spi_data}, exp_spi[0]);
        end
        if (hs) begin
          if (exp_spi.size() != 0) tmp9 = exp_spi.pop_front();
          xfers++;
          if (pos == 0) cmd = bus.o_spi_data;
          resp = 8'hA5;
          if (cmd == 8'h05 && pos == 1) begin
            st = 1'b0;
            if (wip_stuck) st = 1'b1;
            else if (wip_ones > 0) begin
              wip_ones--;
              st = 1'b1;
            end
            resp = {7'b1010101, st};
          end else if (cmd == 8'h03 && pos >= 4) begin
            resp = 8'(pos - 4);
          end
          pend = 1'b1;
          pos  = bus.o_spi_last ? 0 : pos + 1;
        end
        if (bus.o_read_valid) begin
          if (exp_rd.size() == 0) check_eq("rd_extra", bus.o_read_valid, 0);
          else begin
            tmp10 = exp_rd.pop_front();
            check_eq("rd_beat", {bus.o_read_sop, bus.o_read_eop, bus.o_read_data}, tmp10);
          end
        end
      end
      @(posedge clk); #1;
      bus.i_spi_rvalid = pend;
      bus.i_spi_rdata  = resp;
      bus.i_spi_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    int base;
    rst_n = 1'b0;
    bus.i_operation_type  = 2'd0;
    bus.i_operation_addr  = 24'd0;
    bus.i_operation_num   = 9'd0;
    bus.i_operation_valid = 1'b0;
    bus.i_write_data  = 8'h00;
    bus.i_write_sop   = 1'b0;
    bus.i_write_eop   = 1'b0;
    bus.i_write_valid = 1'b0;
    wip_ones  = 0;
    wip_stuck = 1'b0;
    rand_rdy  = 1'b0;
    xfers     = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", bus.o_operation_ready, 0);
    check_eq("rst_spi_vld", bus.o_spi_valid, 0);
    check_eq("rst_spi_last", bus.o_spi_last, 0);
    check_eq("rst_spi_dat", bus.o_spi_data, 0);
    check_eq("rst_rd", {bus.o_read_valid, bus.o_read_sop, bus.o_read_eop, bus.o_read_data}, 0);
    check_eq("rst_timeout", bus.o_timeout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rdy_rise", bus.o_operation_ready, 1);
    @(negedge clk);

    // Erase with WIP busy for two polls.
    wip_ones = 2;
    push(8'h06, 1'b1);
    push_hdr(8'h20, 24'h000100, 1'b1);
    repeat (3) push_poll();
    do_op(2'd0, 24'h000100, 9'd0);
    wait_idle("erase_done");
    check_eq("erase_left", exp_spi.size(), 0);
    check_eq("erase_timeout", bus.o_timeout, 0);

    // Full-page program, one write beat per cycle.
    for (int i = 0; i < 256; i++) pdata[i] = 8'(i);
    do_prog(24'h000100, 9'd256, 0);

    do_read(24'h000100, 9'd256);

    // Random SPI ready with a slow write stream forces PROG_DATA stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 256; i++) pdata[i] = 8'($urandom_range(0, 255));
    do_prog(24'h00ABCD, 9'd20, 2);
    do_read(24'hFFFF00, 9'd0);
    rand_rdy = 1'b0;

    do_read(24'h123456, 9'd1);

    // Reserved type: no SPI traffic, back to ready two cycles after acceptance.
    do_op(2'd3, 24'h000000, 9'd5);
    @(negedge clk);
    check_eq("rsv_rdy", bus.o_operation_ready, 1);

    // Stuck WIP: four polls then sticky timeout.
    wip_stuck = 1'b1;
    push(8'h06, 1'b1);
    push_hdr(8'h20, 24'h0000AA, 1'b1);
    repeat (4) push_poll();
    do_op(2'd0, 24'h0000AA, 9'd0);
    wait_idle("to_done");
    check_eq("to_left", exp_spi.size(), 0);
    check_eq("to_flag", bus.o_timeout, 1);
    wip_stuck = 1'b0;
    do_read(24'h000200, 9'd2);
    check_eq("to_sticky", bus.o_timeout, 1);

    // Reset in the middle of PROG_DATA while it waits on the write stream.
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) pdata[i] = 8'hC0 + 8'(i);
    push(8'h06, 1'b1);
    push_hdr(8'h02, 24'h000300, 1'b0);
    for (int i = 0; i < 16; i++) push(pdata[i], i == 15);
    base = xfers;
    do_op(2'd1, 24'h000300, 9'd16);
    write_stream(8, 16, 1);
    for (int i = 0; i < 2000 && xfers < base + 13; i++) @(negedge clk);
    check_eq("xfer_wait", 32'(xfers >= base + 13), 1);
    repeat (2) @(negedge clk);
    check_eq("stall_vld", bus.o_spi_valid, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", bus.o_operation_ready, 0);
    check_eq("mid_rst_spi", {bus.o_spi_valid, bus.o_spi_last, bus.o_spi_data}, 0);
    check_eq("mid_rst_rd", bus.o_read_valid, 0);
    check_eq("mid_rst_timeout", bus.o_timeout, 0);
    exp_spi.delete();
    exp_rd.delete();
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_rdy_hold", bus.o_operation_ready, 0);
    @(posedge clk); #1;
    check_eq("mid_rst_rdy_rise", bus.o_operation_ready, 1);
    @(negedge clk);
    do_read(24'h000010, 9'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
